// File: rtl/pkt_spi_sequencer_pkg.sv
// Shared definitions for the RX packet readout sequencer: FSM encoding and
// default sizing of packet, byte index, frame timeout and CS synchroniser.
package pkt_spi_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_ARM     = 3'd3,
        ST_XFER    = 3'd4
    } state_t;

    localparam int PKT_NBYTES      = 8;
    localparam int PKT_IDX_W       = 3;
    localparam int DEF_TO_CYCLES   = 4096;
    localparam int DEF_SYNC_STAGES = 2;

    // Width of a counter that must hold 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_spi_sequencer_if.sv
// Control/status bundle between the RX packet path, the SPI slave and the
// readout sequencer; the sequencer takes the master view.
interface pkt_spi_sequencer_if
    import pkt_spi_sequencer_pkg::*;
#(
    parameter int IDX_W = PKT_IDX_W
);
    logic             rx_mode;
    logic             pkt_rec;
    logic             cs_n;
    logic             ovr_clr;
    logic             pkt_ld;
    logic             pkt_rst;
    logic             spi_ld;
    logic [IDX_W-1:0] byte_sel;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             overrun;

    modport master (
        input  rx_mode, pkt_rec, cs_n, ovr_clr,
        output pkt_ld, pkt_rst, spi_ld, byte_sel, busy, done, timeout, overrun
    );

    modport slave (
        output rx_mode, pkt_rec, cs_n, ovr_clr,
        input  pkt_ld, pkt_rst, spi_ld, byte_sel, busy, done, timeout, overrun
    );
endinterface

// File: rtl/pkt_spi_sequencer_cs_sync.sv
// Brings the asynchronous SPI chip select into the clk domain and derives
// single-cycle fall/rise strobes from the synchronised level.
module pkt_spi_sequencer_cs_sync
    import pkt_spi_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    output logic cs_s,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   cs_q_r;

    // Synchroniser chain and edge-detect flop; idle CS level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            cs_q_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], cs_n};
            cs_q_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign cs_s    = sync_r[SYNC_STAGES-1];
    assign cs_fall = cs_q_r & ~cs_s;
    assign cs_rise = ~cs_q_r & cs_s;

endmodule

// File: rtl/pkt_spi_sequencer.sv
// RX readout sequencer: on a new packet, captures it, then presents one byte
// per SPI CS frame with per-frame timeout and overrun detection.
module pkt_spi_sequencer
    import pkt_spi_sequencer_pkg::*;
#(
    parameter int NBYTES      = PKT_NBYTES,
    parameter int IDX_W       = PKT_IDX_W,
    parameter int TO_CYCLES   = DEF_TO_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input logic                 clk,
    input logic                 rst,
    pkt_spi_sequencer_if.master bus
);

    localparam int               TCNT_W   = cnt_width(TO_CYCLES);
    localparam logic [TCNT_W-1:0] TO_LAST  = TCNT_W'(TO_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};

    state_t            state_r;
    logic              pkt_rec_q_r;
    logic [TCNT_W-1:0] tcnt_r;
    logic [IDX_W-1:0]  byte_sel_r;
    logic              pkt_ld_r;
    logic              pkt_rst_r;
    logic              spi_ld_r;
    logic              busy_r;
    logic              done_r;
    logic              timeout_r;
    logic              overrun_r;

    logic              pkt_rise_s;
    logic              cs_lvl_s;
    logic              cs_fall_s;
    logic              cs_rise_s;

    pkt_spi_sequencer_cs_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (bus.cs_n),
        .cs_s    (cs_lvl_s),
        .cs_fall (cs_fall_s),
        .cs_rise (cs_rise_s)
    );

    assign pkt_rise_s = bus.pkt_rec & ~pkt_rec_q_r;

    // Sequencer FSM with byte index, frame timeout, overrun flag and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pkt_rec_q_r <= 1'b0;
            tcnt_r      <= {TCNT_W{1'b0}};
            byte_sel_r  <= IDX_ZERO;
            pkt_ld_r    <= 1'b0;
            pkt_rst_r   <= 1'b0;
            spi_ld_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            pkt_rec_q_r <= bus.pkt_rec;
            pkt_ld_r    <= 1'b0;
            pkt_rst_r   <= 1'b0;
            spi_ld_r    <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;

            // A packet edge while still busy is dropped; setting beats clearing.
            if (pkt_rise_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_r <= 1'b0;
            end

            if (!bus.rx_mode) begin
                state_r    <= ST_IDLE;
                byte_sel_r <= IDX_ZERO;
                busy_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (pkt_rise_s) begin
                            state_r <= ST_CAPTURE;
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        pkt_ld_r   <= 1'b1;
                        byte_sel_r <= IDX_ZERO;
                        state_r    <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        spi_ld_r  <= 1'b1;
                        pkt_rst_r <= (byte_sel_r == IDX_ZERO);
                        tcnt_r    <= {TCNT_W{1'b0}};
                        state_r   <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (cs_fall_s && !cs_lvl_s) begin
                            tcnt_r  <= {TCNT_W{1'b0}};
                            state_r <= ST_XFER;
                        end else if (tcnt_r == TO_LAST) begin
                            timeout_r  <= 1'b1;
                            byte_sel_r <= IDX_ZERO;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            tcnt_r <= tcnt_r + TCNT_W'(1);
                        end
                    end
                    ST_XFER: begin
                        // Frame completion is checked first so a late final rise still reports done.
                        if (cs_rise_s) begin
                            if (byte_sel_r == IDX_LAST) begin
                                done_r     <= 1'b1;
                                byte_sel_r <= IDX_ZERO;
                                busy_r     <= 1'b0;
                                state_r    <= ST_IDLE;
                            end else begin
                                byte_sel_r <= byte_sel_r + IDX_W'(1);
                                state_r    <= ST_LOAD;
                            end
                        end else if (tcnt_r == TO_LAST) begin
                            timeout_r  <= 1'b1;
                            byte_sel_r <= IDX_ZERO;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            tcnt_r <= tcnt_r + TCNT_W'(1);
                        end
                    end
                    default: begin
                        byte_sel_r <= IDX_ZERO;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pkt_ld   = pkt_ld_r;
    assign bus.pkt_rst  = pkt_rst_r;
    assign bus.spi_ld   = spi_ld_r;
    assign bus.byte_sel = byte_sel_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.timeout  = timeout_r;
    assign bus.overrun  = overrun_r;

endmodule
